// File: rtl/dma_arbiter_pkg.sv
// Shared types and constants for the DMA engine arbiter.
package dma_arbiter_pkg;

  // Width of one channel's priority field; 3 is the highest priority.
  localparam int unsigned DmaPrioW = 2;

  // Default watchdog limit in BUSY cycles.
  localparam int unsigned DmaArbTimeoutDefault = 65535;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StGrant   = 3'd1,
    StStart   = 3'd2,
    StBusy    = 3'd3,
    StDoneOk  = 3'd4,
    StDoneErr = 3'd5
  } arb_state_e;

endpackage

// File: rtl/dma_arbiter_if.sv
// Channel/engine handshake bundle. The master side is the arbiter; the slave side is the
// set of channels plus the engine.
interface dma_arbiter_if
  import dma_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
);

  logic                       arb_enable;
  logic [NUM_CH-1:0]          ch_request;
  logic [DmaPrioW*NUM_CH-1:0] ch_priority;
  logic [NUM_CH-1:0]          ch_grant;
  logic [NUM_CH-1:0]          ch_done;
  logic [NUM_CH-1:0]          ch_error;
  logic [CH_W-1:0]            eng_sel;
  logic                       eng_start;
  logic                       eng_done;
  logic                       eng_error;
  logic                       eng_abort;
  logic                       arb_busy;
  logic                       timeout_irq;

  modport master (
    input  arb_enable, ch_request, ch_priority, eng_done, eng_error,
    output ch_grant, ch_done, ch_error, eng_sel, eng_start, eng_abort, arb_busy, timeout_irq
  );

  modport slave (
    output arb_enable, ch_request, ch_priority, eng_done, eng_error,
    input  ch_grant, ch_done, ch_error, eng_sel, eng_start, eng_abort, arb_busy, timeout_irq
  );

endinterface

// File: rtl/dma_arbiter_picker.sv
// Combinational winner selection: highest priority among requesters, ties broken
// round-robin starting just after rr_ptr_i.
module dma_arbiter_picker
  import dma_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0]          req_i,
  input  logic [DmaPrioW*NUM_CH-1:0] prio_i,
  input  logic [CH_W-1:0]            rr_ptr_i,
  output logic [CH_W-1:0]            winner_o,
  output logic                       valid_o
);

  logic [DmaPrioW-1:0] max_prio;
  logic [NUM_CH-1:0]   top_req;  // requesters sitting at the maximum priority
  logic                found;
  logic [CH_W-1:0]     idx;

  // Find the top priority, then scan rr_ptr+1, rr_ptr+2, ... for the first top requester.
  always_comb begin
    max_prio = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_i[i] && (prio_i[DmaPrioW*i +: DmaPrioW] > max_prio)) begin
        max_prio = prio_i[DmaPrioW*i +: DmaPrioW];
      end
    end
    top_req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      top_req[i] = req_i[i] && (prio_i[DmaPrioW*i +: DmaPrioW] == max_prio);
    end
    found    = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(rr_ptr_i) + k) % NUM_CH);
      if (!found && top_req[idx]) begin
        found    = 1'b1;
        winner_o = idx;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/dma_arbiter.sv
// Shares one DMA engine among NUM_CH channels: grant -> start -> done/error/timeout.
// Every output is registered and moves together with the state it belongs to.
module dma_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CH_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = DmaArbTimeoutDefault,
  parameter int unsigned TMR_W          = 16
) (
  input logic            clk,
  input logic            rst,
  dma_arbiter_if.master  bus
);

  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   eng_sel_q, eng_sel_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [NUM_CH-1:0] ch_grant_q, ch_grant_d;
  logic [NUM_CH-1:0] ch_done_q, ch_done_d;
  logic [NUM_CH-1:0] ch_error_q, ch_error_d;
  logic              eng_start_q, eng_start_d;
  logic              eng_abort_q, eng_abort_d;
  logic              arb_busy_q, arb_busy_d;
  logic              timeout_irq_q, timeout_irq_d;

  logic [CH_W-1:0]   pick_winner;
  logic              pick_valid;
  logic [NUM_CH-1:0] sel_oh;
  logic              wdog_expired;

  dma_arbiter_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .req_i    (bus.ch_request),
    .prio_i   (bus.ch_priority),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_winner),
    .valid_o  (pick_valid)
  );

  assign sel_oh       = NUM_CH'(1) << eng_sel_q;
  assign wdog_expired = (TIMEOUT_CYCLES != 0) && (tmr_q == TmrLast);

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    eng_sel_d     = eng_sel_q;
    rr_ptr_d      = rr_ptr_q;
    tmr_d         = tmr_q;
    ch_grant_d    = '0;
    ch_done_d     = '0;
    ch_error_d    = '0;
    eng_start_d   = 1'b0;
    eng_abort_d   = 1'b0;
    timeout_irq_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.arb_enable && pick_valid) begin
          eng_sel_d  = pick_winner;
          ch_grant_d = NUM_CH'(1) << pick_winner;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        eng_start_d = 1'b1;
        state_d     = StStart;
      end
      StStart: begin
        tmr_d   = '0;
        state_d = StBusy;
      end
      StBusy: begin
        // Error beats done; done beats a watchdog expiry in the same cycle.
        if (bus.eng_error) begin
          ch_done_d  = sel_oh;
          ch_error_d = sel_oh;
          state_d    = StDoneErr;
        end else if (bus.eng_done) begin
          ch_done_d = sel_oh;
          state_d   = StDoneOk;
        end else if (wdog_expired) begin
          ch_done_d     = sel_oh;
          ch_error_d    = sel_oh;
          eng_abort_d   = 1'b1;
          timeout_irq_d = 1'b1;
          state_d       = StDoneErr;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StDoneOk: begin
        rr_ptr_d = eng_sel_q;
        state_d  = StIdle;
      end
      StDoneErr: begin
        rr_ptr_d   = eng_sel_q;
        ch_error_d = ch_error_q;  // error stays up through the following IDLE cycle
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    arb_busy_d = (state_d != StIdle);
  end

  // State and output registers; reset drops any transfer in flight without notification.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      eng_sel_q     <= '0;
      rr_ptr_q      <= CH_W'(NUM_CH - 1);
      tmr_q         <= '0;
      ch_grant_q    <= '0;
      ch_done_q     <= '0;
      ch_error_q    <= '0;
      eng_start_q   <= 1'b0;
      eng_abort_q   <= 1'b0;
      arb_busy_q    <= 1'b0;
      timeout_irq_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      eng_sel_q     <= eng_sel_d;
      rr_ptr_q      <= rr_ptr_d;
      tmr_q         <= tmr_d;
      ch_grant_q    <= ch_grant_d;
      ch_done_q     <= ch_done_d;
      ch_error_q    <= ch_error_d;
      eng_start_q   <= eng_start_d;
      eng_abort_q   <= eng_abort_d;
      arb_busy_q    <= arb_busy_d;
      timeout_irq_q <= timeout_irq_d;
    end
  end

  assign bus.ch_grant    = ch_grant_q;
  assign bus.ch_done     = ch_done_q;
  assign bus.ch_error    = ch_error_q;
  assign bus.eng_sel     = eng_sel_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_abort   = eng_abort_q;
  assign bus.arb_busy    = arb_busy_q;
  assign bus.timeout_irq = timeout_irq_q;

endmodule
